// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for a shared decoder path: eight requesters, a registered
// binary/one-hot grant, a mandatory one-cycle release gap and a hold-time limit.
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       grant_valid,
  output logic [2:0] grant_idx,
  output logic [7:0] grant_onehot,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_MAX  = 4'(MAX_HOLD);
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] idx_nxt;
  logic [3:0] hold, hold_nxt;
  logic       valid_nxt;
  logic       timeout_nxt;
  logic [7:0] onehot_nxt;

  // First set request at or after the pointer; walking the offsets downward
  // lets the smallest offset win the last assignment.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] cand;
    sel = p;
    for (int k = 7; k >= 0; k--) begin
      cand = p + 3'(k);
      if (r[cand]) sel = cand;
    end
    return sel;
  endfunction

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = grant_idx;
    hold_nxt    = hold;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          idx_nxt   = rr_pick(req, ptr);
          hold_nxt  = 4'd0;
          valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        hold_nxt = (hold == HOLD_MAX) ? hold : hold + 4'd1;
        // Owner completion or withdrawal outranks the hold limit, so a
        // timeout is only flagged when neither of those happened.
        if (done || !req[grant_idx]) begin
          state_nxt = RELEASE;
          ptr_nxt   = grant_idx + 3'd1;
        end else if (hold == HOLD_LAST) begin
          state_nxt   = RELEASE;
          ptr_nxt     = grant_idx + 3'd1;
          timeout_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    onehot_nxt = valid_nxt ? (8'd1 << idx_nxt) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 3'd0;
      grant_idx    <= 3'd0;
      hold         <= 4'd0;
      grant_valid  <= 1'b0;
      grant_onehot <= 8'h00;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      grant_idx    <= idx_nxt;
      hold         <= hold_nxt;
      grant_valid  <= valid_nxt;
      grant_onehot <= onehot_nxt;
      timeout      <= timeout_nxt;
    end
  end

endmodule
